// File: rtl/approx_arith_pkg.sv
// approx_arith_pkg: shared mode constants and the LOA/exact reference adder.
// loa_ref returns {cout,sum} (w+1 bits, zero-extended to 65) for operands of
// width w; approx=MODE_LOA with k>0 ORs the k LSBs and feeds A[k-1]&B[k-1]
// into bit k, ignoring cin; otherwise it is the exact A+B+cin.
package approx_arith_pkg;
    localparam logic MODE_ACC = 1'b0;
    localparam logic MODE_LOA = 1'b1;

    function automatic logic [64:0] loa_ref(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic approx,
                                           input int w, input int k);
        logic [64:0] r;
        if (approx != MODE_LOA || k == 0)
            r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        else
            r = ((({1'b0, a} >> k) + ({1'b0, b} >> k) + {64'd0, a[k-1] & b[k-1]}) << k)
              | ({1'b0, a | b} & ((65'd1 << k) - 65'd1));
        return r & ((65'd1 << (w + 1)) - 65'd1);
    endfunction
endpackage

// File: rtl/approx_rca_pipe_if.sv
// approx_rca_pipe_if: operand/result handshake bus of approx_rca_pipe.
// in_*: operand beat (valid/ready, A, B, cin, mode); out_*: result beat
// (valid/ready, sum, cout, err); err_count/err_clr: error statistics.
// slave = adder side, master = producer/consumer side.
interface approx_rca_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_approx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_err;
    logic [CNT_W-1:0] err_count;
    logic             err_clr;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_approx, out_ready, err_clr,
        output in_ready, out_valid, out_sum, out_cout, out_err, err_count
    );
    modport master (
        output in_valid, in_a, in_b, in_cin, in_approx, out_ready, err_clr,
        input  in_ready, out_valid, out_sum, out_cout, out_err, err_count
    );
endinterface

// File: rtl/rca_seg.sv
// rca_seg: W-bit combinational ripple-carry adder.
// a_i, b_i: operands; c_i: carry in; s_o: sum; c_o: carry out.
module rca_seg #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W:0] c;
    assign c[0] = c_i;
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign c_o = c[W];
endmodule

// File: rtl/approx_rca_pipe.sv
// approx_rca_pipe: SEG-bit-per-stage pipelined RCA with runtime LOA mode.
// clk, rst_n (async active-low); bus (slave): operand beat in, result beat
// out with error flag, saturating error counter with synchronous clear.
// Each stage adds one segment of both the exact and the selected chain; the
// final stage registers the selected result and the mismatch flag.
module approx_rca_pipe
    import approx_arith_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SEG         = 4,
    parameter int APPROX_BITS = 4,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst_n,
    approx_rca_pipe_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;
    // LSBs replaced by OR, and the single bit (k-1) whose AND forms the LOA carry
    localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> (WIDTH - APPROX_BITS);
    localparam logic [WIDTH-1:0] HB_MASK = LO_MASK ^ (LO_MASK >> 1);

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // stage inputs: index 0 is the operand port, index s>0 is stage s-1's register
    logic             v_s  [STAGES];
    logic             m_s  [STAGES];
    logic             ce_s [STAGES];
    logic             cx_s [STAGES];
    logic [WIDTH-1:0] a_s  [STAGES];
    logic [WIDTH-1:0] b_s  [STAGES];
    logic [WIDTH-1:0] se_s [STAGES];
    logic [WIDTH-1:0] sx_s [STAGES];

    assign v_s[0]  = bus.in_valid;
    assign m_s[0]  = bus.in_approx;
    assign a_s[0]  = bus.in_a;
    assign b_s[0]  = bus.in_b;
    assign ce_s[0] = bus.in_cin;
    assign cx_s[0] = (bus.in_approx == MODE_LOA && APPROX_BITS > 0) ? 1'b0 : bus.in_cin;
    assign se_s[0] = '0;
    assign sx_s[0] = '0;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * SEG;
        localparam logic [SEG-1:0] LM = LO_MASK[LO +: SEG];
        localparam logic [SEG-1:0] HM = HB_MASK[LO +: SEG];
        logic [SEG-1:0] ae, be, ax, bx, sum_e, sum_x;
        logic co_e, co_x;
        logic [WIDTH-1:0] se_d, sx_d;

        assign ae = a_s[s][LO +: SEG];
        assign be = b_s[s][LO +: SEG];
        // LOA: zero the OR'd bits except bit k-1, where A&B on both operands
        // makes the adder emit exactly the LOA carry into bit k
        assign ax = (m_s[s] == MODE_LOA) ? (ae & ~LM) | (ae & be & HM) : ae;
        assign bx = (m_s[s] == MODE_LOA) ? (be & ~LM) | (ae & be & HM) : be;

        rca_seg #(.W(SEG)) u_exact (.a_i(ae), .b_i(be), .c_i(ce_s[s]), .s_o(sum_e), .c_o(co_e));
        rca_seg #(.W(SEG)) u_sel   (.a_i(ax), .b_i(bx), .c_i(cx_s[s]), .s_o(sum_x), .c_o(co_x));

        always_comb begin
            se_d = se_s[s];
            sx_d = sx_s[s];
            se_d[LO +: SEG] = sum_e;
            sx_d[LO +: SEG] = (m_s[s] == MODE_LOA) ? (sum_x & ~LM) | ((ae | be) & LM) : sum_x;
        end

        if (s < STAGES - 1) begin : g_mid
            logic             v_q, m_q, ce_q, cx_q;
            logic [WIDTH-1:0] a_q, b_q, se_q, sx_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q  <= 1'b0;
                    m_q  <= MODE_ACC;
                    ce_q <= 1'b0;
                    cx_q <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                    se_q <= '0;
                    sx_q <= '0;
                end else if (adv) begin
                    v_q  <= v_s[s];
                    m_q  <= m_s[s];
                    ce_q <= co_e;
                    cx_q <= co_x;
                    a_q  <= a_s[s];
                    b_q  <= b_s[s];
                    se_q <= se_d;
                    sx_q <= sx_d;
                end
            end
            assign v_s[s+1]  = v_q;
            assign m_s[s+1]  = m_q;
            assign ce_s[s+1] = ce_q;
            assign cx_s[s+1] = cx_q;
            assign a_s[s+1]  = a_q;
            assign b_s[s+1]  = b_q;
            assign se_s[s+1] = se_q;
            assign sx_s[s+1] = sx_q;
        end else begin : g_out
            logic             out_valid_q, out_cout_q, out_err_q, out_cout_d, out_err_d;
            logic [WIDTH-1:0] out_sum_q, out_sum_d;
            assign out_sum_d  = (m_s[s] == MODE_LOA) ? sx_d : se_d;
            assign out_cout_d = (m_s[s] == MODE_LOA) ? co_x : co_e;
            assign out_err_d  = (m_s[s] == MODE_LOA) && ({co_x, sx_d} != {co_e, se_d});
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_sum_q   <= '0;
                    out_cout_q  <= 1'b0;
                    out_err_q   <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= v_s[s];
                    out_sum_q   <= out_sum_d;
                    out_cout_q  <= out_cout_d;
                    out_err_q   <= out_err_d;
                end
            end
            assign bus.out_valid = out_valid_q;
            assign bus.out_sum   = out_sum_q;
            assign bus.out_cout  = out_cout_q;
            assign bus.out_err   = out_err_q;

            if (APPROX_BITS > 0) begin : g_chk
                a_loa_ref : assert property (@(posedge clk) disable iff (!rst_n)
                    (v_s[s] && m_s[s] == MODE_LOA) |->
                    ({co_x, sx_d} == (WIDTH + 1)'(loa_ref(64'(a_s[s]), 64'(b_s[s]), 1'b0,
                                                         MODE_LOA, WIDTH, APPROX_BITS))));
            end
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb
        cnt_d = bus.err_clr ? '0
              : (bus.out_valid && bus.out_ready && bus.out_err && cnt_q != '1) ? cnt_q + CNT_W'(1)
              : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_approx_rca_pipe.sv
// tb_approx_rca_pipe: scoreboard bench for approx_rca_pipe (16/4/4, CNT_W=4).
module tb_approx_rca_pipe;
    import approx_arith_pkg::*;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, ap;
        logic [15:0] sum;
        logic        cout, err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_rca_pipe_if #(.WIDTH(16), .CNT_W(4)) bus ();
    approx_rca_pipe #(.WIDTH(16), .SEG(4), .APPROX_BITS(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    beat_t stim[$];
    beat_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int n_del = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, req);
        end
    endtask

    function automatic beat_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic ap, input logic [15:0] s, input logic co, input logic er);
        beat_t r;
        r.a = a; r.b = b; r.cin = cin; r.ap = ap; r.sum = s; r.cout = co; r.err = er;
        return r;
    endfunction

    function automatic beat_t mk_ref(input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic ap);
        beat_t r;
        logic [64:0] x, e;
        x = loa_ref(64'(a), 64'(b), cin, ap, 16, 4);
        e = loa_ref(64'(a), 64'(b), cin, MODE_ACC, 16, 4);
        r.a = a; r.b = b; r.cin = cin; r.ap = ap;
        r.sum = x[15:0]; r.cout = x[16]; r.err = (x[16:0] != e[16:0]);
        return r;
    endfunction

    // driver: presents the head of stim each cycle, moves it to the scoreboard on acceptance
    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_approx = 1'b0;
        forever begin
            logic acc;
            @(negedge clk);
            if (stim.size() > 0) begin
                bus.in_valid = 1'b1; bus.in_a = stim[0].a; bus.in_b = stim[0].b;
                bus.in_cin = stim[0].cin; bus.in_approx = stim[0].ap;
            end else bus.in_valid = 1'b0;
            #1 acc = bus.in_valid && bus.in_ready && rst_n;
            @(posedge clk);
            if (acc && stim.size() > 0) begin
                exp_q.push_back(stim[0]);
                void'(stim.pop_front());
            end
        end
    end

    // monitor: compares every delivered result against the scoreboard head
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_del++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: sum=0x%0h delivered, expected no result", bus.out_sum);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("sum", 32'(bus.out_sum), 32'(e.sum));
                chk("cout", 32'(bus.out_cout), 32'(e.cout));
                chk("err", 32'(bus.out_err), 32'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string n);
        int t = 0;
        while ((stim.size() > 0 || exp_q.size() > 0) && t < 200) begin
            tick(1);
            t++;
        end
        checks++;
        if (stim.size() > 0 || exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d beats pending, expected 0", n, stim.size() + exp_q.size());
        end
        tick(2);
    endtask

    initial begin
        int t;
        bus.out_ready = 1'b1;
        bus.err_clr = 1'b0;
        tick(3);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_sum", 32'(bus.out_sum), 0);
        chk("rst_out_cout", 32'(bus.out_cout), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // accurate add with latency check
        stim.push_back(mk(16'h00FF, 16'h0001, 1'b0, MODE_ACC, 16'h0100, 1'b0, 1'b0));
        tick(3);
        chk("latency_early", 32'(bus.out_valid), 0);
        tick(1);
        chk("latency_on_time", 32'(bus.out_valid), 1);
        drain("accurate");
        chk("cnt_after_acc", 32'(bus.err_count), 0);

        // LOA, same operands
        stim.push_back(mk(16'h00FF, 16'h0001, 1'b0, MODE_LOA, 16'h00FF, 1'b0, 1'b1));
        drain("loa");
        chk("cnt_after_loa", 32'(bus.err_count), 1);

        // back-to-back: LOA carry, accurate with cin, LOA agreeing with exact
        stim.push_back(mk(16'hFFFF, 16'h0008, 1'b1, MODE_LOA, 16'h000F, 1'b1, 1'b1));
        stim.push_back(mk(16'hFFFF, 16'h0000, 1'b1, MODE_ACC, 16'h0000, 1'b1, 1'b0));
        stim.push_back(mk(16'h1230, 16'h0005, 1'b0, MODE_LOA, 16'h1235, 1'b0, 1'b0));
        drain("mixed");
        chk("cnt_after_mixed", 32'(bus.err_count), 2);

        // backpressure
        bus.out_ready = 1'b0;
        stim.push_back(mk(16'h0001, 16'h0001, 1'b0, MODE_ACC, 16'h0002, 1'b0, 1'b0));
        stim.push_back(mk(16'h1000, 16'h2000, 1'b0, MODE_ACC, 16'h3000, 1'b0, 1'b0));
        stim.push_back(mk(16'h000F, 16'h0001, 1'b0, MODE_LOA, 16'h000F, 1'b0, 1'b1));
        stim.push_back(mk(16'hFFFF, 16'h0001, 1'b0, MODE_ACC, 16'h0000, 1'b1, 1'b0));
        stim.push_back(mk(16'h00F0, 16'h0F00, 1'b1, MODE_ACC, 16'h0FF1, 1'b0, 1'b0));
        stim.push_back(mk(16'h8000, 16'h8000, 1'b0, MODE_LOA, 16'h0000, 1'b1, 1'b0));
        tick(6);
        chk("bp_accepted_left", 32'(stim.size()), 2);
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        chk("bp_hold_sum0", 32'(bus.out_sum), 32'h0002);
        tick(3);
        chk("bp_hold_valid", 32'(bus.out_valid), 1);
        chk("bp_hold_sum1", 32'(bus.out_sum), 32'h0002);
        chk("bp_hold_left", 32'(stim.size()), 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp_burst_valid", 32'(bus.out_valid), 1);
            tick(1);
        end
        chk("bp_burst_end", 32'(bus.out_valid), 0);
        drain("backpressure");
        chk("cnt_after_bp", 32'(bus.err_count), 3);

        // reset with three beats in flight (first one parked at the output)
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            stim.push_back(mk(16'h00FF, 16'h0001, 1'b0, MODE_LOA, 16'h00FF, 1'b0, 1'b1));
        tick(5);
        chk("mid_pre_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_sum", 32'(bus.out_sum), 0);
        chk("mid_rst_cnt", 32'(bus.err_count), 0);
        stim.delete();
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        t = n_del;
        tick(10);
        chk("mid_no_stale", 32'(n_del - t), 0);
        chk("mid_cnt_after", 32'(bus.err_count), 0);

        // saturation
        for (int i = 0; i < 14; i++)
            stim.push_back(mk_ref(16'h0100 * 16'(i) + 16'h000F, 16'h0001, 1'b0, MODE_LOA));
        drain("sat14");
        chk("cnt_14", 32'(bus.err_count), 14);
        for (int i = 0; i < 3; i++)
            stim.push_back(mk_ref(16'h0F0F, 16'h0001, 1'b1, MODE_LOA));
        drain("sat17");
        chk("cnt_saturated", 32'(bus.err_count), 15);

        // clear coinciding with an erroneous delivery
        stim.push_back(mk(16'h00FF, 16'h0001, 1'b0, MODE_LOA, 16'h00FF, 1'b0, 1'b1));
        t = 0;
        while (!bus.out_valid && t < 20) begin
            tick(1);
            t++;
        end
        chk("clr_result_seen", 32'(bus.out_valid), 1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("clr_priority", 32'(bus.err_count), 0);
        drain("clr");
        stim.push_back(mk(16'h00FF, 16'h0001, 1'b0, MODE_LOA, 16'h00FF, 1'b0, 1'b1));
        drain("post_clr");
        chk("cnt_post_clr", 32'(bus.err_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/approx_rca_pipe.md
Name: approx_rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder that generalises the team's 4-bit accurate RCA to WIDTH bits.
- Adds a per-transaction runtime mode: accurate, or lower-part-OR approximate (LOA).
- Splits the carry chain into SEG-bit pipeline stages and uses valid/ready handshakes on both sides.
- Computes the exact result alongside the approximate one, flags any mismatch and counts errors. This gives the characterisation harness error statistics in silicon.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG; must be ≥1.
- APPROX_BITS, 4, LSBs replaced by OR in approx mode; range 0..WIDTH.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry in.
- in_approx  in  1  1 = LOA mode, 0 = accurate.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  selected-mode sum.
- out_cout  out  1  selected-mode carry out.
- out_err  out  1  {out_cout,out_sum} differs from the exact {cout,sum}.
- err_count  out  CNT_W  number of delivered results with out_err=1, saturating.
- err_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset (async assert, sync release): all stage valids 0; out_valid=0, out_sum=0, out_cout=0, out_err=0, err_count=0. in_ready reads 1 once reset is released.
- Reset mid-operation: every in-flight beat is discarded; no partial result ever appears on the outputs.
- Handshake rules:
  - A beat is accepted when in_valid & in_ready; a result is delivered when out_valid & out_ready.
  - Global advance: adv = !out_valid | out_ready; in_ready = adv. The whole pipeline shifts only when adv=1.
  - While stalled, every stage register and all outputs hold their values; out_sum/out_cout/out_err stay stable until the result is taken.
  - in_valid=0 inserts a bubble; bubbles are not collapsed.
  - Accept and deliver in the same cycle is legal; throughput is 1 beat/cycle.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stall. STAGES=1 gives a single registered adder with 1-cycle latency.
- Ordering: strictly in-order; capacity is STAGES beats.
- Datapath, stage s (0..STAGES-1):
  - Adds bits [s*SEG +: SEG] of both the exact chain and the selected chain.
  - Registers both segment carries, the completed low segments, and the not-yet-added operand bits plus the mode bit, all moving forward with the beat (skewed-operand ripple).
- Exact chain: {cout,sum} = A + B + cin, full WIDTH+1 result.
- Approx chain (in_approx=1, k=APPROX_BITS):
  - sum[k-1:0] = A[k-1:0] | B[k-1:0].
  - Carry into bit k = A[k-1] & B[k-1]; in_cin is ignored.
  - Upper bits are an exact ripple add using that carry.
  - k=0: the approx chain equals the exact chain, so out_err is always 0.
  - k=WIDTH: the whole word is ORed, with cout = A[W-1] & B[W-1].
- Accurate mode: out_sum/out_cout come from the exact chain and out_err=0.
- out_err is registered with the result: 1 iff the approx and exact {cout,sum} differ.
- err_count:
  - Increments on each delivery with out_err=1.
  - Saturates at 2^CNT_W-1; never wraps.
  - err_clr has priority over a simultaneous increment (result is 0).

Decomposition:
- Shared package approx_arith_pkg holds:
  - mode constants MODE_ACC=0, MODE_LOA=1;
  - a function computing the LOA reference value, shared by RTL assertions and the bench scoreboard.
- One natural sub-module: rca_seg (SEG-bit combinational ripple adder with carry in/out), instantiated twice per stage via generate (exact and selected chains).

Test Plan (defaults WIDTH=16, SEG=4, APPROX_BITS=4):
- Accurate: A=0x00FF, B=0x0001, cin=0, approx=0, out_ready=1 -> after 4 cycles sum=0x0100, cout=0, err=0.
- LOA: same operands, approx=1 -> sum=0x00FF, cout=0, err=1, err_count=1.
- LOA with carry: A=0xFFFF, B=0x0008, cin=1, approx=1 -> sum=0x000F, cout=1, err=1 (exact would be 0x0008/1).
- Backpressure: out_ready=0 and 6 consecutive valid beats -> exactly 4 accepted, then in_ready=0. Outputs hold steady while stalled. After out_ready=1, all 6 results emerge in order, one per cycle.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; no stale result appears after release; err_count=0.
- Saturation and clear (CNT_W=4): 17 erroneous beats -> err_count=15. Then err_clr together with a further erroneous delivery -> err_count=0.
